// File: rtl/noisy_tone_gen_if.sv
// Configuration port of noisy_tone_gen: tone frequency word and noise
// attenuation, moved with a valid/ready handshake.
interface noisy_tone_gen_if #(
  parameter int PHASE_W = 24
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] cfg_fcw;
  logic [4:0]         cfg_noise_shift;

  modport master (
    output cfg_valid,
    output cfg_fcw,
    output cfg_noise_shift,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_fcw,
    input  cfg_noise_shift,
    output cfg_ready
  );
endinterface

// File: rtl/noisy_tone_gen.sv
// Test-signal source: DDS sine tone plus shifted LFSR noise, saturated to
// signed Q1.15, one sample per enabled clock through a 3-stage pipeline.
//
// state | meaning
// IDLE  | enable low; config writes fcw directly, phase parked at 0
// RUN   | generating; a config write is parked in pending_fcw
// PEND  | generating; pending_fcw waits for the next phase wrap, cfg_ready low
module noisy_tone_gen #(
  parameter int          PHASE_W   = 24,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  noisy_tone_gen_if.slave    cfg,
  output logic signed [15:0] noisy_signal,
  output logic               sample_valid
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] phase, phase_nxt;
  logic [PHASE_W-1:0] fcw, fcw_nxt;
  logic [PHASE_W-1:0] pending_fcw, pending_nxt;
  logic [PHASE_W:0]   phase_sum;
  logic [4:0]         noise_shift;
  logic [15:0]        lfsr;
  logic               xfer;
  logic               wrap;

  logic [PHASE_W-1:0] s1_phase;
  logic [15:0]        s1_lfsr;
  logic               s1_v;

  logic [1:0]         quad;
  logic [5:0]         addr;
  logic [5:0]         idx;
  logic [14:0]        mag;
  logic signed [15:0] tone_c, noise_c;
  logic signed [15:0] tone_r, noise_r;
  logic               s2_v;

  logic signed [16:0] sum;
  logic signed [15:0] sat;

  // Quarter-wave table: round(16383*sin(2*pi*(k+0.5)/256)).
  function automatic logic [14:0] tone_lut(input logic [5:0] k);
    tone_lut = 15'd0;
    case (k)
      6'd0:  tone_lut = 15'd201;   6'd1:  tone_lut = 15'd603;   6'd2:  tone_lut = 15'd1005;  6'd3:  tone_lut = 15'd1406;
      6'd4:  tone_lut = 15'd1806;  6'd5:  tone_lut = 15'd2205;  6'd6:  tone_lut = 15'd2603;  6'd7:  tone_lut = 15'd2999;
      6'd8:  tone_lut = 15'd3393;  6'd9:  tone_lut = 15'd3785;  6'd10: tone_lut = 15'd4175;  6'd11: tone_lut = 15'd4563;
      6'd12: tone_lut = 15'd4948;  6'd13: tone_lut = 15'd5330;  6'd14: tone_lut = 15'd5708;  6'd15: tone_lut = 15'd6083;
      6'd16: tone_lut = 15'd6455;  6'd17: tone_lut = 15'd6822;  6'd18: tone_lut = 15'd7186;  6'd19: tone_lut = 15'd7545;
      6'd20: tone_lut = 15'd7900;  6'd21: tone_lut = 15'd8249;  6'd22: tone_lut = 15'd8594;  6'd23: tone_lut = 15'd8934;
      6'd24: tone_lut = 15'd9268;  6'd25: tone_lut = 15'd9597;  6'd26: tone_lut = 15'd9920;  6'd27: tone_lut = 15'd10237;
      6'd28: tone_lut = 15'd10548; 6'd29: tone_lut = 15'd10852; 6'd30: tone_lut = 15'd11150; 6'd31: tone_lut = 15'd11441;
      6'd32: tone_lut = 15'd11726; 6'd33: tone_lut = 15'd12003; 6'd34: tone_lut = 15'd12273; 6'd35: tone_lut = 15'd12536;
      6'd36: tone_lut = 15'd12791; 6'd37: tone_lut = 15'd13038; 6'd38: tone_lut = 15'd13278; 6'd39: tone_lut = 15'd13509;
      6'd40: tone_lut = 15'd13733; 6'd41: tone_lut = 15'd13948; 6'd42: tone_lut = 15'd14154; 6'd43: tone_lut = 15'd14353;
      6'd44: tone_lut = 15'd14542; 6'd45: tone_lut = 15'd14723; 6'd46: tone_lut = 15'd14895; 6'd47: tone_lut = 15'd15058;
      6'd48: tone_lut = 15'd15212; 6'd49: tone_lut = 15'd15356; 6'd50: tone_lut = 15'd15492; 6'd51: tone_lut = 15'd15618;
      6'd52: tone_lut = 15'd15735; 6'd53: tone_lut = 15'd15842; 6'd54: tone_lut = 15'd15940; 6'd55: tone_lut = 15'd16028;
      6'd56: tone_lut = 15'd16106; 6'd57: tone_lut = 15'd16175; 6'd58: tone_lut = 15'd16234; 6'd59: tone_lut = 15'd16283;
      6'd60: tone_lut = 15'd16323; 6'd61: tone_lut = 15'd16352; 6'd62: tone_lut = 15'd16372; 6'd63: tone_lut = 15'd16382;
      default: tone_lut = 15'd0;
    endcase
  endfunction

  assign cfg.cfg_ready = (state != PEND);
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign phase_sum     = {1'b0, phase} + {1'b0, fcw};
  assign wrap          = phase_sum[PHASE_W];

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    fcw_nxt     = fcw;
    pending_nxt = pending_fcw;
    if (enable) phase_nxt = phase_sum[PHASE_W-1:0];
    case (state)
      IDLE: begin
        if (xfer) fcw_nxt = cfg.cfg_fcw;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (xfer) pending_nxt = cfg.cfg_fcw;
        if (!enable) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else if (xfer) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (!enable) begin
          state_nxt = IDLE;
          phase_nxt = '0;
          fcw_nxt   = pending_fcw;
        end else if (wrap) begin
          // the wrapping step itself still uses the old word
          state_nxt = RUN;
          fcw_nxt   = pending_fcw;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign quad = s1_phase[PHASE_W-1 -: 2];
  assign addr = s1_phase[PHASE_W-3 -: 6];
  assign idx  = quad[0] ? (6'd63 - addr) : addr;
  assign mag  = tone_lut(idx);

  always_comb begin
    tone_c = $signed({1'b0, mag});
    if (quad[1]) tone_c = -$signed({1'b0, mag});
  end

  always_comb begin
    noise_c = '0;
    if (!noise_shift[4]) noise_c = $signed(s1_lfsr) >>> noise_shift[3:0];
  end

  assign sum = $signed({tone_r[15], tone_r}) + $signed({noise_r[15], noise_r});

  always_comb begin
    sat = sum[15:0];
    if (sum[16] != sum[15]) sat = sum[16] ? 16'sh8000 : 16'sh7FFF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      phase        <= '0;
      fcw          <= '0;
      pending_fcw  <= '0;
      noise_shift  <= 5'd16;
      lfsr         <= LFSR_SEED;
      s1_phase     <= '0;
      s1_lfsr      <= '0;
      s1_v         <= 1'b0;
      tone_r       <= '0;
      noise_r      <= '0;
      s2_v         <= 1'b0;
      noisy_signal <= '0;
      sample_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      fcw         <= fcw_nxt;
      pending_fcw <= pending_nxt;
      if (xfer) noise_shift <= cfg.cfg_noise_shift;
      s1_v <= enable;
      if (enable) begin
        s1_phase <= phase;
        s1_lfsr  <= lfsr;
        lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      end
      tone_r       <= tone_c;
      noise_r      <= noise_c;
      s2_v         <= s1_v;
      noisy_signal <= s2_v ? sat : 16'sd0;
      sample_valid <= s2_v;
    end
  end

endmodule

// File: tb/tb_noisy_tone_gen.sv
// Directed bench for noisy_tone_gen: DC, quadrature tone, noise, clamp,
// retune at phase wrap, enable drop and reset during a pending retune.
module tb_noisy_tone_gen;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] noisy_signal;
  logic               sample_valid;
  int                 n_cmp = 0;
  int                 n_bad = 0;
  int                 tone4[4] = '{201, 16382, -201, -16382};

  noisy_tone_gen_if #(.PHASE_W(24)) cfg_bus ();

  noisy_tone_gen #(.PHASE_W(24), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg          (cfg_bus),
    .noisy_signal (noisy_signal),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int s16(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input logic [23:0] f, input logic [4:0] sh);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_fcw = f;
    cfg_bus.cfg_noise_shift = sh;
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_fcw = '0;
    cfg_bus.cfg_noise_shift = '0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", sample_valid); end
    n_cmp++;
    if (noisy_signal !== 16'sd0) begin n_bad++; $display("FAIL reset_signal: got %0d want 0", noisy_signal); end
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", cfg_bus.cfg_ready); end
  endtask

  task automatic test_dc();
    do_reset();
    enable = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      n_cmp++;
      if (sample_valid !== (t >= 3)) begin n_bad++; $display("FAIL dc_valid t=%0d: got %0b want %0b", t, sample_valid, (t >= 3)); end
      n_cmp++;
      if (int'(noisy_signal) !== ((t >= 3) ? 201 : 0)) begin
        n_bad++; $display("FAIL dc_value t=%0d: got %0d want %0d", t, noisy_signal, (t >= 3) ? 201 : 0);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_tone_period();
    int j;
    do_reset();
    cfg_write(24'h400000, 5'd16);
    enable = 1'b1;
    j = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (sample_valid === 1'b1) begin
        n_cmp++;
        if (int'(noisy_signal) !== tone4[j % 4]) begin
          n_bad++; $display("FAIL tone4 sample %0d: got %0d want %0d", j, noisy_signal, tone4[j % 4]);
        end
        j++;
      end
    end
    n_cmp++;
    if (j !== 12) begin n_bad++; $display("FAIL tone4_count: got %0d want 12", j); end
    enable = 1'b0;
  endtask

  task automatic test_noise();
    logic [15:0] model;
    int          j, e;
    do_reset();
    cfg_write(24'h000000, 5'd0);
    enable = 1'b1;
    model = 16'hACE1;
    j = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t >= 3) begin
        n_cmp++;
        if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL noise_valid t=%0d: got %0b want 1", t, sample_valid); end
        e = clamp16(201 + s16(model));
        n_cmp++;
        if (int'(noisy_signal) !== e) begin n_bad++; $display("FAIL noise sample %0d: got %0d want %0d", j, noisy_signal, e); end
        if (j == 0) begin
          n_cmp++;
          if (int'(noisy_signal) !== -21078) begin n_bad++; $display("FAIL noise_first: got %0d want -21078", noisy_signal); end
        end
        if (j == 1) begin
          n_cmp++;
          if (int'(noisy_signal) !== -7367) begin n_bad++; $display("FAIL noise_second: got %0d want -7367", noisy_signal); end
        end
        model = lfsr_step(model);
        j++;
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_clamp();
    logic [15:0] model;
    int          j, e;
    bit          saw_pos, saw_neg;
    do_reset();
    cfg_write(24'h400000, 5'd0);
    enable = 1'b1;
    model = 16'hACE1;
    j = 0;
    saw_pos = 1'b0;
    saw_neg = 1'b0;
    for (int t = 0; t < 3000 && !(saw_pos && saw_neg); t++) begin
      tick();
      if (sample_valid === 1'b1) begin
        e = clamp16(tone4[j % 4] + s16(model));
        n_cmp++;
        if (int'(noisy_signal) !== e) begin n_bad++; $display("FAIL clamp sample %0d: got %0d want %0d", j, noisy_signal, e); end
        if (e == 32767) saw_pos = 1'b1;
        if (e == -32768) saw_neg = 1'b1;
        model = lfsr_step(model);
        j++;
      end
    end
    n_cmp++;
    if (!(saw_pos && saw_neg)) begin
      n_bad++; $display("FAIL clamp_reach: got pos=%0b neg=%0b want both 1", saw_pos, saw_neg);
    end
    enable = 1'b0;
  endtask

  task automatic test_retune();
    int exp_seq[14] = '{201, 16382, -201, -16382, 201, 11726, 16382, 11441,
                        -201, -11726, -16382, -11441, 201, 11726};
    int j;
    do_reset();
    cfg_write(24'h400000, 5'd16);
    enable = 1'b1;
    tick();
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL retune_ready_run: got %0b want 1", cfg_bus.cfg_ready); end
    j = 0;
    for (int t = 2; t <= 16; t++) begin
      cfg_bus.cfg_valid = (t == 2);
      cfg_bus.cfg_fcw = 24'h200000;
      cfg_bus.cfg_noise_shift = 5'd16;
      tick();
      cfg_bus.cfg_valid = 1'b0;
      if (t >= 2 && t <= 4) begin
        n_cmp++;
        if (cfg_bus.cfg_ready !== (t == 4)) begin
          n_bad++; $display("FAIL retune_ready t=%0d: got %0b want %0b", t, cfg_bus.cfg_ready, (t == 4));
        end
      end
      if (sample_valid === 1'b1 && j < 14) begin
        n_cmp++;
        if (int'(noisy_signal) !== exp_seq[j]) begin
          n_bad++; $display("FAIL retune sample %0d: got %0d want %0d", j, noisy_signal, exp_seq[j]);
        end
        j++;
      end
    end
    n_cmp++;
    if (j !== 14) begin n_bad++; $display("FAIL retune_count: got %0d want 14", j); end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ev;
    int e;
    do_reset();
    cfg_write(24'h400000, 5'd16);
    for (int t = 1; t <= 16; t++) begin
      enable = (t <= 6) || (t >= 9);
      tick();
      ev = ((t >= 3) && (t <= 8)) || (t >= 11);
      n_cmp++;
      if (sample_valid !== ev) begin n_bad++; $display("FAIL drop_valid t=%0d: got %0b want %0b", t, sample_valid, ev); end
      if (!ev) e = 0;
      else if (t <= 8) e = tone4[(t - 3) % 4];
      else e = tone4[(t - 11) % 4];
      n_cmp++;
      if (int'(noisy_signal) !== e) begin n_bad++; $display("FAIL drop_value t=%0d: got %0d want %0d", t, noisy_signal, e); end
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_pend();
    logic [15:0] model;
    int          e;
    do_reset();
    cfg_write(24'h400000, 5'd16);
    enable = 1'b1;
    tick();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_fcw = 24'h200000;
    cfg_bus.cfg_noise_shift = 5'd0;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL pend_ready: got %0b want 0", cfg_bus.cfg_ready); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL rstpend_valid: got %0b want 0", sample_valid); end
    n_cmp++;
    if (noisy_signal !== 16'sd0) begin n_bad++; $display("FAIL rstpend_signal: got %0d want 0", noisy_signal); end
    n_cmp++;
    if (cfg_bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rstpend_ready: got %0b want 1", cfg_bus.cfg_ready); end
    model = 16'hACE1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      model = lfsr_step(model);
      n_cmp++;
      if (int'(noisy_signal) !== ((t >= 3) ? 201 : 0)) begin
        n_bad++; $display("FAIL rstpend_dc t=%0d: got %0d want %0d", t, noisy_signal, (t >= 3) ? 201 : 0);
      end
    end
    enable = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    cfg_write(24'h000000, 5'd0);
    enable = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t >= 3) begin
        e = clamp16(201 + s16(model));
        n_cmp++;
        if (int'(noisy_signal) !== e) begin n_bad++; $display("FAIL rstpend_lfsr t=%0d: got %0d want %0d", t, noisy_signal, e); end
        model = lfsr_step(model);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dc();
    test_tone_period();
    test_noise();
    test_clamp();
    test_retune();
    test_back_to_back();
    test_reset_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
